fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch byte address after reset.
REQ-002 The block SHALL have parameter ADDR_W, default 30, giving the word-address width driven to instruction memory.
REQ-003 The block SHALL have parameter DEPTH, default 2, giving the instruction buffer entry count (power of two, >=2).
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 en  input  1  fetch enable; low blocks new memory reads.
REQ-007 redirect  input  1  load `target` as the new fetch PC and flush.
REQ-008 target  input  32  redirect byte address.
REQ-009 mem_re  output  1  memory read strobe.
REQ-010 mem_addr  output  ADDR_W  word address, equal to fetch_pc[ADDR_W+1:2].
REQ-011 mem_rdata  input  32  synchronous read data, valid exactly one cycle after mem_re.
REQ-012 inst_valid  output  1  buffer head holds an instruction.
REQ-013 inst_ready  input  1  consumer accepts the head.
REQ-014 inst  output  32  head instruction word.
REQ-015 inst_pc  output  32  byte address of the head instruction.
REQ-016 misaligned  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-017 A transfer SHALL occur in any cycle with inst_valid and inst_ready both high, and SHALL pop exactly one entry.
REQ-018 mem_re SHALL be high iff en=1, redirect=0, not halted, and count+inflight-pop < DEPTH. inflight is 1 if mem_re was high in the previous cycle and not cancelled; pop is 1 if a transfer occurs this cycle.
REQ-019 Each issued read SHALL advance fetch_pc by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 Returned data SHALL be written to the buffer tail one cycle after issue, tagged with the PC of the issued read.
REQ-021 Instructions SHALL leave in issue order with no loss or duplication; the head SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-022 With a continuously ready consumer and en=1, the block SHALL sustain one instruction per cycle.
REQ-023 redirect=1 SHALL empty the buffer, discard the in-flight read's data, and set fetch_pc=target.
REQ-024 After redirect at cycle t, mem_re SHALL rise at t+1 with address target, and inst_valid SHALL rise at t+3.
REQ-025 A transfer in the same cycle as redirect SHALL count as completed; the flush SHALL still apply.
REQ-026 Lowering en SHALL allow the in-flight read to complete into the buffer; buffered entries remain consumable.
REQ-027 inst and inst_pc are don't-care while inst_valid=0.

Reset
REQ-028 While resetn=0: fetch_pc=RESET_PC, buffer empty, inflight=0, mem_re=0, inst_valid=0, misaligned=0.
REQ-029 Reset asserted mid-operation SHALL discard buffered and in-flight instructions immediately.
REQ-030 The first mem_re SHALL occur in the first cycle after resetn deasserts with en=1, at address RESET_PC>>2.

Configuration
REQ-031 With FETCH_MISALIGN_EN defined: redirect with target[1:0]!=0 SHALL set misaligned=1 and halt issue (no mem_re) until a redirect with an aligned target, which clears misaligned and resumes normally.
REQ-032 Without FETCH_MISALIGN_EN: misaligned SHALL be constant 0, and target[1:0] SHALL be ignored (treated as 00).

Verification
REQ-033 Reset release, RESET_PC=0, memory word k = k, inst_ready=1 -> mem_re from cycle 1; inst/inst_pc stream 0/0, 1/4, 2/8, ... one per cycle.
REQ-034 inst_ready=0 for 5 cycles, DEPTH=2 -> exactly 2 entries buffered, mem_re low; ready restored -> PCs 0,4,8 consecutive with no gap or repeat.
REQ-035 redirect to 32'h100 while buffer full -> inst_valid low at t+1 and t+2; inst_pc=32'h100 at t+3; no stale PC ever emitted.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 FETCH_MISALIGN_EN defined, redirect to 32'h102 -> misaligned=1, mem_re=0 for 10 cycles; redirect to 32'h200 -> misaligned=0, inst_pc=32'h200.
REQ-038 resetn pulsed low mid-stream with 2 entries buffered -> inst_valid=0 at once; after release, stream restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC, one-cycle synchronous memory read, DEPTH-entry buffer.
// Optional misaligned-redirect trap is built when FETCH_MISALIGN_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 30,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              redirect,
    input  logic [31:0]       target,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              misaligned
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = PTR_W + 2;
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [31:0]      fetch_pc_p0;
    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic [31:0]      buf_inst [DEPTH];
    logic [31:0]      buf_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             halted;
    logic [31:0]      redirect_pc;
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;

`ifdef FETCH_MISALIGN_EN
    logic mis_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mis_q <= 1'b0;
        end else if (redirect) begin
            mis_q <= (target[1:0] != 2'b00);
        end
    end

    assign halted      = mis_q;
    assign misaligned  = mis_q;
    assign redirect_pc = target;
`else
    // Low target bits are deliberately dropped; fetch always stays word aligned.
    logic unused_target_bits;
    assign unused_target_bits = ^target[1:0];
    assign halted      = 1'b0;
    assign misaligned  = 1'b0;
    assign redirect_pc = {target[31:2], 2'b00};
`endif

    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = vld_p1 & ~redirect;
    // Occupancy seen by a read issued now: entries held plus the one landing, minus the one leaving.
    assign occ        = OCC_W'(count) + OCC_W'(vld_p1) - OCC_W'(pop);
    assign issue      = resetn & en & ~redirect & ~halted & (occ < DEPTH_V);
    assign mem_re     = issue;
    assign mem_addr   = fetch_pc_p0[ADDR_W+1:2];
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

    // Stage p0 -> p1: PC register and in-flight read tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_p0 <= RESET_PC;
            vld_p1      <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc_p0 <= redirect_pc;
            vld_p1      <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (issue) begin
                fetch_pc_p0 <= next_pc(fetch_pc_p0);
            end
            vld_p1 <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= fetch_pc_p0;
        end
    end

    // Stage p1 -> buffer: returned word lands at the tail tagged with its PC
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= mem_rdata;
            buf_pc[wr_ptr]   <= pc_p1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed latency/boundary cases then randomized en/ready/redirect traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ADDR_W   = 30;
    localparam int          DEPTH    = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              en;
    logic              redirect;
    logic [31:0]       target;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              misaligned;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] stream_next = '0;
    logic        stream_on   = 1'b0;
    logic        model_mis   = 1'b0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] mon_exp;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .redirect  (redirect),
        .target    (target),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    // Memory: word k holds k, returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= 32'(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic top_up();
        while (stream_on && exp_q.size() < 8) begin
            exp_q.push_back(stream_next);
            stream_next = stream_next + 32'd4;
        end
    endtask

    task automatic start_stream(input logic [31:0] start, input logic on);
        exp_q.delete();
        stream_on   = on;
        stream_next = start;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every transfer against the expected instruction stream.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                model_mis    = 1'b0;
                hold_pending = 1'b0;
                start_stream(RESET_PC, 1'b1);
            end else begin
                chk1("misaligned_flag", misaligned, model_mis);
`ifdef FETCH_MISALIGN_EN
                if (model_mis) chk1("halted_mem_re", mem_re, 1'b0);
`endif
                if (hold_pending) begin
                    chk1("hold_valid", inst_valid, 1'b1);
                    chk("hold_pc", inst_pc, hold_pc);
                end
                hold_pending = inst_valid && !inst_ready && !redirect;
                hold_pc      = inst_pc;
                if (inst_valid && inst_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_inst: got pc %h with nothing expected", inst_pc);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("inst_pc", inst_pc, mon_exp);
                        chk("inst_data", inst, {2'b00, mon_exp[31:2]});
                        top_up();
                    end
                end
                if (redirect) begin
`ifdef FETCH_MISALIGN_EN
                    model_mis = (target[1:0] != 2'b00);
                    start_stream(target, !model_mis);
`else
                    start_stream({target[31:2], 2'b00}, 1'b1);
`endif
                end
            end
        end
    end

    initial begin
        int x0;
        resetn     = 1'b0;
        en         = 1'b1;
        redirect   = 1'b0;
        target     = '0;
        inst_ready = 1'b1;
        step();
        step();
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_misaligned", misaligned, 1'b0);

        // Reset release: first read in the first cycle, head valid two cycles later.
        resetn = 1'b1;
        #1;
        chk1("rel_mem_re", mem_re, 1'b1);
        chk("rel_mem_addr", 32'(mem_addr), RESET_PC >> 2);
        chk1("rel_valid_c0", inst_valid, 1'b0);
        step();
        chk1("rel_valid_c1", inst_valid, 1'b0);
        step();
        chk1("rel_valid_c2", inst_valid, 1'b1);
        chk("rel_first_pc", inst_pc, RESET_PC);

        x0 = xfers;
        repeat (20) step();
        chk("throughput", 32'(xfers - x0), 32'd20);

        // Consumer stall then release.
        inst_ready = 1'b0;
        repeat (5) step();
        chk1("stall_mem_re", mem_re, 1'b0);
        chk1("stall_valid", inst_valid, 1'b1);
        inst_ready = 1'b1;
        #1;
        chk1("unstall_mem_re", mem_re, 1'b1);
        chk1("unstall_valid_c0", inst_valid, 1'b1);
        step();
        chk1("unstall_valid_c1", inst_valid, 1'b1);
        step();
        chk1("unstall_valid_c2", inst_valid, 1'b1);

        // Redirect with a full buffer and a same-cycle transfer.
        inst_ready = 1'b0;
        repeat (3) step();
        inst_ready = 1'b1;
        redirect   = 1'b1;
        target     = 32'h0000_0100;
        #1;
        chk1("redir_mem_re_t0", mem_re, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        chk1("redir_mem_re_t1", mem_re, 1'b1);
        chk("redir_addr_t1", 32'(mem_addr), 32'h40);
        chk1("redir_valid_t1", inst_valid, 1'b0);
        step();
        chk1("redir_valid_t2", inst_valid, 1'b0);
        step();
        chk1("redir_valid_t3", inst_valid, 1'b1);
        chk("redir_pc_t3", inst_pc, 32'h0000_0100);

        // Misaligned redirect.
        redirect = 1'b1;
        target   = 32'h0000_0102;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            chk1("mis_set", misaligned, 1'b1);
            chk1("mis_no_read", mem_re, 1'b0);
            step();
        end
        redirect = 1'b1;
        target   = 32'h0000_0200;
        step();
        redirect = 1'b0;
        #1;
        chk1("mis_cleared", misaligned, 1'b0);
        chk1("mis_resume_re", mem_re, 1'b1);
        chk("mis_resume_addr", 32'(mem_addr), 32'h80);
        step();
        step();
        chk1("mis_resume_valid", inst_valid, 1'b1);
        chk("mis_resume_pc", inst_pc, 32'h0000_0200);
`else
        #1;
        chk1("mis_const0", misaligned, 1'b0);
        chk("mis_ignored_addr", 32'(mem_addr), 32'h40);
        step();
        step();
        chk("mis_ignored_pc", inst_pc, 32'h0000_0100);
        chk("mis_ignored_inst", inst, 32'h40);
`endif

        // PC wrap at the top of the address space.
        redirect = 1'b1;
        target   = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        step();
        step();
        chk1("wrap_valid", inst_valid, 1'b1);
        chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
        step();
        chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc2", inst_pc, 32'h0000_0000);

        // Fetch disable: in-flight read completes, buffer drains, then empties.
        en         = 1'b0;
        inst_ready = 1'b0;
        #1;
        chk1("en_low_mem_re", mem_re, 1'b0);
        repeat (4) step();
        chk1("en_low_buffered", inst_valid, 1'b1);
        inst_ready = 1'b1;
        step();
        step();
        chk1("en_low_drained", inst_valid, 1'b0);
        en = 1'b1;
        repeat (3) step();

        // Asynchronous reset with a full buffer.
        inst_ready = 1'b0;
        repeat (4) step();
        chk1("pre_rst_valid", inst_valid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk1("async_rst_valid", inst_valid, 1'b0);
        chk1("async_rst_mem_re", mem_re, 1'b0);
        inst_ready = 1'b1;
        step();
        step();
        resetn = 1'b1;
        #1;
        chk1("rerel_mem_re", mem_re, 1'b1);
        chk("rerel_addr", 32'(mem_addr), RESET_PC >> 2);
        step();
        step();
        chk1("rerel_valid", inst_valid, 1'b1);
        chk("rerel_pc", inst_pc, RESET_PC);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step();
            en         = ($urandom_range(0, 9) != 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect   = ($urandom_range(0, 24) == 0);
            if (redirect) begin
                case ($urandom_range(0, 2))
                    0:       target = $urandom;
                    1:       target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: target = $urandom & 32'h0000_0FFF;
                endcase
`ifdef FETCH_MISALIGN_EN
                if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
`endif
            end
        end
        step();
        redirect = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
